// File: rtl/move_executor.sv
// Keyboard-driven grid mover: edge-detects direction presses, queues them in a small
// FIFO and applies one queued move per game tick with wall clamping.
module move_executor #(
   parameter int GRID_W  = 8,
   parameter int GRID_H  = 8,
   parameter int X_BITS  = 3,
   parameter int Y_BITS  = 3,
   parameter int START_X = 0,
   parameter int START_Y = 0,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2:0]               kb_in,
   input  logic                     step_en,
   output logic [X_BITS-1:0]        pos_x,
   output logic [Y_BITS-1:0]        pos_y,
   output logic [2:0]               dir_out,
   output logic                     moved,
   output logic                     bump,
   output logic                     drop,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int PTR_BITS = $clog2(DEPTH);

   typedef logic [PTR_BITS-1:0] ptr_t;
   typedef logic [PTR_BITS:0]   cnt_t;

   localparam logic [2:0]        DIR_UP    = 3'd1;
   localparam logic [2:0]        DIR_DOWN  = 3'd2;
   localparam logic [2:0]        DIR_LEFT  = 3'd3;
   localparam logic [2:0]        DIR_RIGHT = 3'd4;
   localparam ptr_t              PTR_ONE   = ptr_t'(1);
   localparam cnt_t              CNT_ONE   = cnt_t'(1);
   localparam cnt_t              CNT_FULL  = cnt_t'(DEPTH);
   localparam logic [X_BITS-1:0] X_ONE     = X_BITS'(1);
   localparam logic [Y_BITS-1:0] Y_ONE     = Y_BITS'(1);
   localparam logic [X_BITS-1:0] X_MAX     = X_BITS'(GRID_W - 1);
   localparam logic [Y_BITS-1:0] Y_MAX     = Y_BITS'(GRID_H - 1);

   logic [2:0]        kb_prev_reg;
   ptr_t              rd_ptr_reg, wr_ptr_reg;
   cnt_t              count_reg, count_next;
   logic [X_BITS-1:0] pos_x_reg, pos_x_next;
   logic [Y_BITS-1:0] pos_y_reg, pos_y_next;
   logic [2:0]        dir_reg;
   logic              moved_reg, bump_reg, drop_reg;

   logic [2:0]        fifo_mem [DEPTH];
   logic [2:0]        head;
   logic              new_press, push, pop, drop_next, blocked;

   assign new_press = (kb_in >= DIR_UP) && (kb_in <= DIR_RIGHT) && (kb_in != kb_prev_reg);
   assign pop       = step_en && (count_reg != '0);
   assign push      = new_press && ((count_reg != CNT_FULL) || pop);
   assign drop_next = new_press && (count_reg == CNT_FULL) && !pop;

   // Asynchronous head read: the popped code must steer the position update on the
   // same edge. When full, a same-cycle push overwrites this slot only after the edge.
   assign head = fifo_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= kb_in;
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   // Bounds are tested before stepping so the position can never wrap.
   always_comb begin
      blocked    = 1'b0;
      pos_x_next = pos_x_reg;
      pos_y_next = pos_y_reg;
      case (head)
         DIR_UP:    if (pos_y_reg == '0)   blocked = 1'b1; else pos_y_next = pos_y_reg - Y_ONE;
         DIR_DOWN:  if (pos_y_reg == Y_MAX) blocked = 1'b1; else pos_y_next = pos_y_reg + Y_ONE;
         DIR_LEFT:  if (pos_x_reg == '0)   blocked = 1'b1; else pos_x_next = pos_x_reg - X_ONE;
         DIR_RIGHT: if (pos_x_reg == X_MAX) blocked = 1'b1; else pos_x_next = pos_x_reg + X_ONE;
         default:   blocked = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kb_prev_reg <= 3'd0;
         rd_ptr_reg  <= '0;
         wr_ptr_reg  <= '0;
         count_reg   <= '0;
         pos_x_reg   <= X_BITS'(START_X);
         pos_y_reg   <= Y_BITS'(START_Y);
         dir_reg     <= 3'd0;
         moved_reg   <= 1'b0;
         bump_reg    <= 1'b0;
         drop_reg    <= 1'b0;
      end else begin
         kb_prev_reg <= kb_in;
         count_reg   <= count_next;
         drop_reg    <= drop_next;
         moved_reg   <= pop && !blocked;
         bump_reg    <= pop && blocked;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            dir_reg    <= head;
            pos_x_reg  <= pos_x_next;
            pos_y_reg  <= pos_y_next;
         end
      end
   end

   assign pos_x   = pos_x_reg;
   assign pos_y   = pos_y_reg;
   assign dir_out = dir_reg;
   assign moved   = moved_reg;
   assign bump    = bump_reg;
   assign drop    = drop_reg;
   assign q_count = count_reg;

endmodule

// File: tb/tb_move_executor.sv
// Directed bench for move_executor: a vector table for the main queue/execute flow
// plus hand-written sequences for hold, wall, and mid-stream reset cases.
module tb_move_executor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] kb_in = 3'd0;
   logic       step_en = 1'b0;
   logic [2:0] pos_x, pos_y, dir_out, q_count;
   logic       moved, bump, drop;

   int checks = 0;
   int failures = 0;

   move_executor #(
      .GRID_W(8), .GRID_H(8), .X_BITS(3), .Y_BITS(3),
      .START_X(0), .START_Y(0), .DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .kb_in(kb_in), .step_en(step_en),
      .pos_x(pos_x), .pos_y(pos_y), .dir_out(dir_out),
      .moved(moved), .bump(bump), .drop(drop), .q_count(q_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] kb;
      logic       step;
      int         x, y, dir, mv, bp, dp, cnt;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; kb_in = 3'd0; step_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic press_step(input logic [2:0] code);
      kb_in = code; step_en = 1'b0; tick();
      kb_in = 3'd0; step_en = 1'b1; tick();
      step_en = 1'b0;
   endtask

   initial begin
      int mv_cnt;

      //                 kb    st  x  y dir mv bp dp cnt
      vecs[0]  = '{3'd4, 1'b0, 0, 0, 0, 0, 0, 0, 1};
      vecs[1]  = '{3'd4, 1'b1, 1, 0, 4, 1, 0, 0, 0};
      vecs[2]  = '{3'd0, 1'b0, 1, 0, 4, 0, 0, 0, 0};
      vecs[3]  = '{3'd1, 1'b0, 1, 0, 4, 0, 0, 0, 1};
      vecs[4]  = '{3'd3, 1'b0, 1, 0, 4, 0, 0, 0, 2};
      vecs[5]  = '{3'd0, 1'b1, 1, 0, 1, 0, 1, 0, 1};
      vecs[6]  = '{3'd0, 1'b1, 0, 0, 3, 1, 0, 0, 0};
      vecs[7]  = '{3'd0, 1'b1, 0, 0, 3, 0, 0, 0, 0};
      vecs[8]  = '{3'd7, 1'b0, 0, 0, 3, 0, 0, 0, 0};
      vecs[9]  = '{3'd2, 1'b0, 0, 0, 3, 0, 0, 0, 1};
      vecs[10] = '{3'd0, 1'b0, 0, 0, 3, 0, 0, 0, 1};
      vecs[11] = '{3'd4, 1'b0, 0, 0, 3, 0, 0, 0, 2};
      vecs[12] = '{3'd2, 1'b0, 0, 0, 3, 0, 0, 0, 3};
      vecs[13] = '{3'd4, 1'b0, 0, 0, 3, 0, 0, 0, 4};
      vecs[14] = '{3'd2, 1'b0, 0, 0, 3, 0, 0, 1, 4};
      vecs[15] = '{3'd4, 1'b1, 0, 1, 2, 1, 0, 0, 4};
      vecs[16] = '{3'd0, 1'b1, 1, 1, 4, 1, 0, 0, 3};
      vecs[17] = '{3'd0, 1'b1, 1, 2, 2, 1, 0, 0, 2};
      vecs[18] = '{3'd0, 1'b1, 2, 2, 4, 1, 0, 0, 1};
      vecs[19] = '{3'd0, 1'b1, 3, 2, 4, 1, 0, 0, 0};

      // Asynchronous reset takes effect before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk("rst_pos_x", pos_x, 0);
      chk("rst_pos_y", pos_y, 0);
      chk("rst_dir", dir_out, 0);
      chk("rst_pulses", {moved, bump, drop}, 0);
      chk("rst_q_count", q_count, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         kb_in = vecs[i].kb; step_en = vecs[i].step;
         tick();
         $display("vec %0d kb=%0d step=%0d -> pos=(%0d,%0d) dir=%0d m=%0d b=%0d d=%0d q=%0d",
                  i, vecs[i].kb, vecs[i].step, pos_x, pos_y, dir_out, moved, bump, drop, q_count);
         chk($sformatf("v%0d_x", i), pos_x, vecs[i].x);
         chk($sformatf("v%0d_y", i), pos_y, vecs[i].y);
         chk($sformatf("v%0d_dir", i), dir_out, vecs[i].dir);
         chk($sformatf("v%0d_moved", i), moved, vecs[i].mv);
         chk($sformatf("v%0d_bump", i), bump, vecs[i].bp);
         chk($sformatf("v%0d_drop", i), drop, vecs[i].dp);
         chk($sformatf("v%0d_q", i), q_count, vecs[i].cnt);
      end
      kb_in = 3'd0; step_en = 1'b0;

      // Holding right for 200 cycles must produce exactly one move.
      do_reset();
      mv_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         kb_in = 3'd4; step_en = (i % 10 == 9);
         tick();
         mv_cnt += int'(moved);
         if (i == 0) chk("hold_q_after_press", q_count, 1);
      end
      $display("hold: moves=%0d pos_x=%0d q=%0d", mv_cnt, pos_x, q_count);
      chk("hold_moves", mv_cnt, 1);
      chk("hold_pos_x", pos_x, 1);
      chk("hold_q_end", q_count, 0);
      kb_in = 3'd0; step_en = 1'b0;

      // Right/bottom walls.
      do_reset();
      for (int i = 0; i < 6; i++) press_step(3'd4);
      chk("wall_x6", pos_x, 6);
      press_step(3'd4);
      $display("wall: right from 6 -> x=%0d moved=%0d bump=%0d", pos_x, moved, bump);
      chk("wall_x7", pos_x, 7);
      chk("wall_x7_moved", moved, 1);
      press_step(3'd4);
      chk("wall_right_bump", bump, 1);
      chk("wall_right_moved", moved, 0);
      chk("wall_right_x", pos_x, 7);
      for (int i = 0; i < 7; i++) press_step(3'd2);
      chk("wall_y7", pos_y, 7);
      press_step(3'd4);
      chk("corner_right_bump", bump, 1);
      press_step(3'd2);
      $display("corner: pos=(%0d,%0d) dir=%0d bump=%0d", pos_x, pos_y, dir_out, bump);
      chk("corner_down_bump", bump, 1);
      chk("corner_pos_x", pos_x, 7);
      chk("corner_pos_y", pos_y, 7);
      chk("corner_dir", dir_out, 2);

      // Reset mid-stream with right held across it.
      do_reset();
      kb_in = 3'd4; tick();
      kb_in = 3'd0; tick();
      kb_in = 3'd2; tick();
      kb_in = 3'd0; tick();
      kb_in = 3'd4; tick();
      chk("mid_q3", q_count, 3);
      step_en = 1'b1; tick();
      step_en = 1'b0;
      chk("mid_x1", pos_x, 1);
      chk("mid_q2", q_count, 2);
      #3 rst = 1'b1;
      #1;
      $display("mid reset: pos=(%0d,%0d) q=%0d moved=%0d", pos_x, pos_y, q_count, moved);
      chk("mid_rst_x", pos_x, 0);
      chk("mid_rst_moved", moved, 0);
      chk("mid_rst_q", q_count, 0);
      repeat (3) @(posedge clk);
      #4 rst = 1'b0;
      tick();
      chk("mid_repress_q", q_count, 1);
      step_en = 1'b1; tick();
      step_en = 1'b0;
      $display("mid after: pos=(%0d,%0d) q=%0d moved=%0d", pos_x, pos_y, q_count, moved);
      chk("mid_after_x", pos_x, 1);
      chk("mid_after_y", pos_y, 0);
      chk("mid_after_moved", moved, 1);
      chk("mid_after_q", q_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/move_executor.md
# move_executor

Consumes the 3-bit direction code from the keyboard front end and turns it into player motion on a bounded grid. Each new key press is captured once (edge-detected), queued in a small FIFO, and applied one move per game tick, updating a registered (x, y) position with wall clamping. Sits between the keyboard decoder and the game/VGA logic that reads the position.

## Interface
Parameters:
- GRID_W, 8: grid width in cells; legal x is 0..GRID_W-1.
- GRID_H, 8: grid height in cells; legal y is 0..GRID_H-1.
- X_BITS, 3: width of pos_x; 2^X_BITS >= GRID_W.
- Y_BITS, 3: width of pos_y; 2^Y_BITS >= GRID_H.
- START_X, 0: reset x position.
- START_Y, 0: reset y position.
- DEPTH, 4: move FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- kb_in  in  3  direction code from keyboard: 000 none, 001 up, 010 down, 011 left, 100 right; 101–111 invalid.
- step_en  in  1  one-cycle game tick; one queued move is executed per tick.
- pos_x  out  X_BITS  current x.
- pos_y  out  Y_BITS  current y.
- dir_out  out  3  code of the last executed move (including bumps).
- moved  out  1  one-cycle pulse: position changed.
- bump  out  1  one-cycle pulse: move executed but blocked by a wall.
- drop  out  1  one-cycle pulse: press discarded because the FIFO was full.
- q_count  out  clog2(DEPTH)+1  number of queued moves.

## Operation
- Press detection: register kb_prev <= kb_in every cycle. new_press = (kb_in in 001..100) && (kb_in != kb_prev). Holding a code yields exactly one press; up -> left directly yields a press for left; release to 000 and re-press yields a new press. Invalid codes never push but do update kb_prev.
- FIFO: circular buffer, DEPTH entries of 3 bits, wrap-around read/write pointers, count register.
  - Push on new_press when count < DEPTH, or when count == DEPTH and a pop happens in the same cycle.
  - Push with count == DEPTH and no pop: press discarded, drop = 1 for that cycle.
  - Pop when step_en && count > 0. step_en with empty FIFO: no action, no pulses.
  - Simultaneous push and pop: count unchanged, both complete.
- Execution of popped code: up y-1, down y+1, left x-1, right x+1 (y = 0 is top row).
  - Move leaving the grid (x = 0 left, x = GRID_W-1 right, y = 0 up, y = GRID_H-1 down): position holds, bump = 1, moved = 0.
  - Otherwise position updates, moved = 1, bump = 0.
  - dir_out <= popped code in both cases.
- No arithmetic wrap: bounds are checked before the add/subtract; position never exceeds grid.

## Timing
- Reset (async assert, all outputs immediately): pos_x = START_X, pos_y = START_Y, dir_out = 000, moved = bump = drop = 0, q_count = 0, pointers = 0, kb_prev = 000.
- kb_in valid before edge E0 -> pushed at E0; q_count increments after E0.
- step_en high in the cycle ending at edge E1 (E1 >= E0 + 1 cycle) -> pop at E1; pos_x/pos_y, dir_out, moved/bump all registered at E1, pulses high for exactly the cycle after E1.
- No bypass: minimum press-to-motion latency is 2 clock edges.
- drop registered at the push edge, one-cycle pulse.
- rst asserted mid-operation: queued moves are lost, pos returns to START; a key still held after rst releases is treated as a new press (kb_prev = 000).

## Test plan
- Reset then kb_in = 100 held 200 cycles, step_en pulsed every 10 cycles -> exactly one move: pos_x 0->1, moved one pulse, q_count 1->0.
- From (0,0), press up, then left, each released to 000, two ticks -> two bump pulses, pos stays (0,0), dir_out = 011 after second.
- Five distinct presses (right, down, right, down, right) with no step_en, DEPTH = 4 -> q_count = 4, one drop pulse on 5th; then 4 ticks -> pos (2,2).
- FIFO full and new_press coincident with step_en -> no drop, q_count stays 4, FIFO order preserved (verify via subsequent pos sequence).
- From (7,7), GRID 8x8, right then down -> two bumps; from (6,0) right, right -> (7,0) then bump.
- Queue 3 moves, assert rst for 3 cycles mid-stream while right held -> outputs reset immediately; after release, one right press queued, next tick pos (1,0).
